halut_encoder_ctrl: RTL and testbench
=====================================

# halut_encoder_ctrl

Sequencer for the `EncUnits` parallel HALUT encoder units. It streams threshold words from a valid/ready source into the units' threshold memories, distributing each word by codebook index. It then holds the encoder enable for exactly the programmed number of rows and checks that every unit returns the expected number of encoded results. It sits between the accelerator's configuration/command interface and the encoder array, and drives all encoder write ports and `encoder_i` enables.

## Interface
- `K`, 16, prototypes per codebook (power of 2)
- `C`, 32, total codebooks (multiple of `EncUnits`)
- `EncUnits`, 4, number of encoder units (power of 2)
- `DataTypeWidth`, 16, threshold word width
- `RowWidth`, 16, width of row count
- derived: `TreeDepth=$clog2(K)`, `CPerEncUnit=C/EncUnits`, `ThreshMemAddrWidth=$clog2(CPerEncUnit*K)`, `NumThresh=C*K`
- `clk_i` in 1: clock
- `rst_ni` in 1: reset, asynchronous, active-low
- `load_i` in 1: pulse; start threshold load (honoured in IDLE only)
- `start_i` in 1: pulse; start encoding run (honoured in IDLE only)
- `num_rows_i` in `RowWidth`: rows to encode; sampled with `start_i`
- `thresh_valid_i` in 1 / `thresh_ready_o` out 1: threshold stream handshake
- `thresh_data_i` in `DataTypeWidth`: threshold word
- `enc_waddr_o` out `ThreshMemAddrWidth`: shared write address to all units
- `enc_wdata_o` out `DataTypeWidth`: shared write data
- `enc_we_o` out `EncUnits`: one-hot write enable, bit n drives unit n
- `enc_en_o` out 1: drives `encoder_i` of all units
- `enc_valid_i` in `EncUnits`: `valid_o` of each unit
- `row_o` out `RowWidth`: index of the row currently being encoded
- `busy_o` out 1: high when not IDLE
- `done_o` out 1: one-cycle pulse at the end of a load or run
- `err_o` out 1: sticky; cleared by the next accepted `load_i` or `start_i`

## Operation
- FSM states: IDLE, LOAD, RUN, DRAIN, DONE.
- **IDLE**
  - `load_i` → LOAD.
  - else `start_i` → RUN, or → DONE if `num_rows_i==0`.
  - `load_i` wins over `start_i` when both are asserted.
  - Pulses outside IDLE are ignored.
- **LOAD**
  - `thresh_ready_o=1`. Word index i counts 0..NumThresh-1 on each handshake.
  - Decode of i: `c=i/K`, `k=i%K`, unit `=c%EncUnits`, local codebook `=c/EncUnits`.
  - Outputs: `enc_waddr_o={local, k}`; `enc_we_o` = one-hot(unit), registered together with addr/data, 1 cycle after the handshake.
  - The handshake at `i==NumThresh-1` → DONE.
- **RUN**
  - `enc_en_o=1`. Nested counters: tree level (0..TreeDepth-1), local codebook (0..CPerEncUnit-1), row (0..num_rows-1).
  - `row_o` increments when the tree-level and codebook counters both wrap.
  - The final count → DRAIN.
  - Results per unit: one `enc_valid_i` bit per unit counted over RUN+DRAIN.
- **DRAIN**: `enc_en_o=0` for 1 cycle while the last valid is collected → DONE.
- **DONE**
  - `done_o=1` for 1 cycle → IDLE.
  - `err_o` sets if the unit-0 valid count ≠ `num_rows*CPerEncUnit`.
  - `err_o` also sets if `enc_valid_i` is ever neither all-0 nor all-1 during RUN/DRAIN.
- **Widths**
  - Valid counter is `RowWidth+$clog2(CPerEncUnit)` bits.
  - Row counter is `RowWidth` bits.
  - No wrap occurs at `num_rows_i=2^RowWidth-1`.

## Timing
- Reset values: all outputs 0; state IDLE; counters 0.
- `thresh_ready_o` is combinational from state only. All other outputs are registered.
- Load latency: write is visible at the unit 1 cycle after the handshake. `done_o` pulses 1 cycle after the last write.
- Back-pressure: `thresh_valid_i` low stalls the index. Gaps are allowed.
- Run latency: with `start_i` sampled at cycle 0, `enc_en_o` is high for cycles 1..N where `N=num_rows*CPerEncUnit*TreeDepth`.
  - Valids arrive at cycles 1+TreeDepth·j, for j=1..N/TreeDepth.
  - DRAIN occurs at N+1; `done_o` at N+2.
- `num_rows_i==0`: `done_o` pulses at cycle 1, with no enable and no error.
- Async reset mid-load or mid-run: immediate return to IDLE with `enc_we_o=0` and `enc_en_o=0`. Partially written thresholds are not restored.

## Structure
- Package `halut_pkg` holds:
  - the `state_e` enum
  - derived constants `TreeDepth`, `CPerEncUnit`, `ThreshMemAddrWidth`
  - the index-split function (word index → unit, local codebook, k)
- Single module; no sub-module. The nested counters stay inline.

## Test plan
Scenarios use the default parameters.
- Load 512 words with value = index → word 17 writes unit 1 at addr 1 (`enc_we_o=4'b0010`); word 80 writes unit 1 at addr 16; word 511 writes unit 3 at addr 127; `done_o` pulses once, 1 cycle after the final write.
- Load with `thresh_valid_i` toggled every other cycle → same 512 writes in the same order; no duplicate or missed index.
- Start with `num_rows_i=2` and 4 encoder models attached → `enc_en_o` high for 64 cycles; 16 valids per unit; `row_o` goes 0→1 at cycle 33; `done_o` at cycle 66; `err_o=0`.
- Same run with the unit-2 model dropping one valid → `err_o=1` at DONE; the next `start_i` clears it.
- `num_rows_i=0` → `done_o` at cycle 1, `enc_en_o` never high. `load_i` and `start_i` in the same cycle → LOAD is entered.
- `rst_ni` asserted at cycle 20 of a run → all outputs 0 immediately; after release, `start_i` with `num_rows_i=1` completes normally (`done_o` at cycle 34).

Source files
------------

// File: rtl/halut_pkg.sv
// Shared types, default geometry and word-index decode for the HALUT encoder sequencer.
package halut_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRun,
    StDrain,
    StDone
  } state_e;

  // Default array geometry
  localparam int unsigned DefK        = 16;
  localparam int unsigned DefC        = 32;
  localparam int unsigned DefEncUnits = 4;

  localparam int unsigned TreeDepth          = $clog2(DefK);
  localparam int unsigned CPerEncUnit        = DefC / DefEncUnits;
  localparam int unsigned ThreshMemAddrWidth = $clog2(CPerEncUnit * DefK);

  typedef struct packed {
    logic [31:0] unit;
    logic [31:0] lcb;
    logic [31:0] k;
  } idx_split_t;

  // Threshold word index -> owning unit, codebook within that unit, prototype slot.
  // Codebooks are dealt round-robin across units.
  function automatic idx_split_t split_index(input logic [31:0] idx,
                                             input logic [31:0] k_protos,
                                             input logic [31:0] enc_units);
    idx_split_t  res;
    logic [31:0] c;
    c        = idx / k_protos;
    res.k    = idx % k_protos;
    res.unit = c % enc_units;
    res.lcb  = c / enc_units;
    return res;
  endfunction

endpackage

// File: rtl/halut_encoder_ctrl.sv
// Sequencer for the parallel HALUT encoder units: threshold load, timed encode run,
// and result-count checking.
module halut_encoder_ctrl
  import halut_pkg::*;
#(
  parameter int unsigned K             = DefK,
  parameter int unsigned C             = DefC,
  parameter int unsigned EncUnits      = DefEncUnits,
  parameter int unsigned DataTypeWidth = 16,
  parameter int unsigned RowWidth      = 16
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 load_i,
  input  logic                                 start_i,
  input  logic [RowWidth-1:0]                  num_rows_i,
  input  logic                                 thresh_valid_i,
  output logic                                 thresh_ready_o,
  input  logic [DataTypeWidth-1:0]             thresh_data_i,
  output logic [$clog2((C/EncUnits)*K)-1:0]    enc_waddr_o,
  output logic [DataTypeWidth-1:0]             enc_wdata_o,
  output logic [EncUnits-1:0]                  enc_we_o,
  output logic                                 enc_en_o,
  input  logic [EncUnits-1:0]                  enc_valid_i,
  output logic [RowWidth-1:0]                  row_o,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic                                 err_o
);

  localparam int unsigned TDepth    = $clog2(K);
  localparam int unsigned CPerUnit  = C / EncUnits;
  localparam int unsigned AddrW     = $clog2(CPerUnit * K);
  localparam int unsigned NumThresh = C * K;
  localparam int unsigned IdxW      = $clog2(NumThresh);
  localparam int unsigned LvlW      = (TDepth > 1) ? $clog2(TDepth) : 1;
  localparam int unsigned CbW       = (CPerUnit > 1) ? $clog2(CPerUnit) : 1;
  localparam int unsigned VcntW     = RowWidth + $clog2(CPerUnit);

  state_e                   state_q, state_d;
  logic [IdxW-1:0]          idx_q, idx_d;
  logic [LvlW-1:0]          lvl_q, lvl_d;
  logic [CbW-1:0]           cb_q, cb_d;
  logic [RowWidth-1:0]      row_q, row_d;
  logic [RowWidth-1:0]      nrows_q, nrows_d;
  logic [VcntW-1:0]         vcnt_q, vcnt_d;
  logic [AddrW-1:0]         waddr_q, waddr_d;
  logic [DataTypeWidth-1:0] wdata_q, wdata_d;
  logic [EncUnits-1:0]      we_q, we_d;
  logic                     en_q, en_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic                     run_q, run_d;
  idx_split_t               split;

  // Next-state, counters and registered-output precompute
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lvl_d   = lvl_q;
    cb_d    = cb_q;
    row_d   = row_q;
    nrows_d = nrows_q;
    vcnt_d  = vcnt_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    we_d    = '0;
    err_d   = err_q;
    run_d   = run_q;
    split   = '0;

    unique case (state_q)
      StIdle: begin
        if (load_i) begin
          state_d = StLoad;
          idx_d   = '0;
          err_d   = 1'b0;
          run_d   = 1'b0;
        end else if (start_i) begin
          state_d = (num_rows_i == '0) ? StDone : StRun;
          nrows_d = num_rows_i;
          lvl_d   = '0;
          cb_d    = '0;
          row_d   = '0;
          vcnt_d  = '0;
          err_d   = 1'b0;
          run_d   = 1'b1;
        end
      end
      StLoad: begin
        if (thresh_valid_i) begin
          split   = split_index(32'(idx_q), K, EncUnits);
          we_d    = EncUnits'(1) << split.unit;
          waddr_d = AddrW'(split.lcb * K + split.k);
          wdata_d = thresh_data_i;
          if (idx_q == IdxW'(NumThresh - 1)) begin
            state_d = StDone;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      StRun: begin
        if (lvl_q == LvlW'(TDepth - 1)) begin
          lvl_d = '0;
          if (cb_q == CbW'(CPerUnit - 1)) begin
            cb_d = '0;
            // Row stays on the last index rather than stepping past it
            if (row_q == nrows_q - RowWidth'(1)) begin
              state_d = StDrain;
            end else begin
              row_d = row_q + RowWidth'(1);
            end
          end else begin
            cb_d = cb_q + CbW'(1);
          end
        end else begin
          lvl_d = lvl_q + LvlW'(1);
        end
      end
      StDrain: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Collect unit-0 results; all units must report in lockstep
    if (state_q == StRun || state_q == StDrain) begin
      vcnt_d = vcnt_q + VcntW'(enc_valid_i[0]);
      if (!(enc_valid_i == '0 || enc_valid_i == '1)) begin
        err_d = 1'b1;
      end
    end
    if (state_q == StDrain && vcnt_d != VcntW'(nrows_q) * VcntW'(CPerUnit)) begin
      err_d = 1'b1;
    end

    en_d   = (state_d == StRun);
    busy_d = (state_d != StIdle);
    // A load reports one cycle after its last write lands; a run reports on entering DONE
    done_d = run_d ? (state_d == StDone) : (state_q == StDone);
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      idx_q   <= '0;
      lvl_q   <= '0;
      cb_q    <= '0;
      row_q   <= '0;
      nrows_q <= '0;
      vcnt_q  <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      we_q    <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lvl_q   <= lvl_d;
      cb_q    <= cb_d;
      row_q   <= row_d;
      nrows_q <= nrows_d;
      vcnt_q  <= vcnt_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      run_q   <= run_d;
    end
  end

  assign thresh_ready_o = (state_q == StLoad);
  assign enc_waddr_o    = waddr_q;
  assign enc_wdata_o    = wdata_q;
  assign enc_we_o       = we_q;
  assign enc_en_o       = en_q;
  assign row_o          = row_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_halut_encoder_ctrl.sv
// Self-checking bench for halut_encoder_ctrl: threshold loads, encode runs, error and reset cases.
module tb_halut_encoder_ctrl;

  localparam int TD  = 4;   // tree depth
  localparam int CPE = 8;   // codebooks per unit
  localparam int NT  = 512; // thresholds

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        load_i = 1'b0;
  logic        start_i = 1'b0;
  logic [15:0] num_rows_i = '0;
  logic        thresh_valid_i = 1'b0;
  logic        thresh_ready_o;
  logic [15:0] thresh_data_i = '0;
  logic [6:0]  enc_waddr_o;
  logic [15:0] enc_wdata_o;
  logic [3:0]  enc_we_o;
  logic        enc_en_o;
  logic [3:0]  enc_valid_i;
  logic [15:0] row_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  halut_encoder_ctrl dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .load_i        (load_i),
    .start_i       (start_i),
    .num_rows_i    (num_rows_i),
    .thresh_valid_i(thresh_valid_i),
    .thresh_ready_o(thresh_ready_o),
    .thresh_data_i (thresh_data_i),
    .enc_waddr_o   (enc_waddr_o),
    .enc_wdata_o   (enc_wdata_o),
    .enc_we_o      (enc_we_o),
    .enc_en_o      (enc_en_o),
    .enc_valid_i   (enc_valid_i),
    .row_o         (row_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o)
  );

  always #5 clk_i = ~clk_i;

  // Encoder-unit models: one result per TD enabled cycles; unit 2 can drop its 3rd result
  bit drop2 = 1'b0;
  int mdl_cnt;
  int mdl_emit;
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mdl_cnt     <= 0;
      mdl_emit    <= 0;
      enc_valid_i <= '0;
    end else begin
      enc_valid_i <= '0;
      if (enc_en_o) begin
        if (mdl_cnt == TD - 1) begin
          mdl_cnt     <= 0;
          mdl_emit    <= mdl_emit + 1;
          enc_valid_i <= (drop2 && mdl_emit == 2) ? 4'b1011 : 4'b1111;
        end else begin
          mdl_cnt <= mdl_cnt + 1;
        end
      end else begin
        mdl_cnt  <= 0;
        mdl_emit <= 0;
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Reference decode of threshold word i
  function automatic int exp_we(input int i);
    return 1 << ((i / 16) % 4);
  endfunction
  function automatic int exp_addr(input int i);
    return ((i / 16) / 4) * 16 + (i % 16);
  endfunction

  logic [15:0] exp_data[NT];
  int          wr_we[$];
  int          wr_addr[$];
  int          wr_data[$];

  function automatic int q_get(input int which, input int i);
    if (which == 0) return (i < wr_we.size()) ? wr_we[i] : -1;
    if (which == 1) return (i < wr_addr.size()) ? wr_addr[i] : -1;
    return (i < wr_data.size()) ? wr_data[i] : -1;
  endfunction

  // mode 0: valid always high, 1: every other cycle, 2: random gaps
  task automatic do_load(input int mode, input bit with_start, input string tag);
    int sent = 0;
    bit hs = 1'b0;
    int done_cnt = 0, done_cyc = -1, last_wr = -1, last_hs = -1, en_seen = 0, nbad = 0;
    int rdy_c1 = 0;
    for (int i = 0; i < NT; i++) exp_data[i] = (mode == 2) ? 16'($urandom) : 16'(i);
    wr_we.delete(); wr_addr.delete(); wr_data.delete();
    load_i  = 1'b1;
    start_i = with_start;
    num_rows_i = 16'd5;
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      tick();
      if (hs) begin
        sent++;
        last_hs = cyc - 1;
      end
      load_i  = 1'b0;
      start_i = 1'b0;
      if (cyc == 1) rdy_c1 = int'(thresh_ready_o);
      if (enc_en_o) en_seen++;
      if (enc_we_o != '0) begin
        wr_we.push_back(int'(enc_we_o));
        wr_addr.push_back(int'(enc_waddr_o));
        wr_data.push_back(int'(enc_wdata_o));
        last_wr = cyc;
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (done_cnt > 0 && cyc >= done_cyc + 3) break;
      if (sent < NT) begin
        case (mode)
          0:       thresh_valid_i = 1'b1;
          1:       thresh_valid_i = cyc[0];
          default: thresh_valid_i = 1'($urandom_range(0, 1));
        endcase
        thresh_data_i = exp_data[sent];
      end else begin
        thresh_valid_i = 1'b0;
      end
      hs = thresh_valid_i && thresh_ready_o;
    end
    thresh_valid_i = 1'b0;
    for (int i = 0; i < NT; i++) begin
      if (q_get(0, i) != exp_we(i) || q_get(1, i) != exp_addr(i) ||
          q_get(2, i) != int'(exp_data[i])) nbad++;
    end
    chk({tag, "_ready_c1"}, rdy_c1, 1);
    chk({tag, "_writes"}, wr_we.size(), NT);
    chk({tag, "_bad_words"}, nbad, 0);
    chk({tag, "_done_count"}, done_cnt, 1);
    chk({tag, "_write_lat"}, last_wr, last_hs + 1);
    chk({tag, "_done_lat"}, done_cyc, last_wr + 1);
    chk({tag, "_en_seen"}, en_seen, 0);
  endtask

  task automatic do_run(input int rows, input bit drop, output int en_cnt, output int first_en,
                        output int last_en, output int done_cyc, output int err_done,
                        output int row1_cyc, output int err_pre, output int err_c1);
    drop2    = drop;
    err_pre  = int'(err_o);
    en_cnt   = 0;
    first_en = -1;
    last_en  = -1;
    done_cyc = -1;
    err_done = -1;
    row1_cyc = -1;
    err_c1   = -1;
    start_i    = 1'b1;
    num_rows_i = 16'(rows);
    for (int cyc = 1; cyc <= rows * 32 + 20; cyc++) begin
      tick();
      start_i = 1'b0;
      if (cyc == 1) err_c1 = int'(err_o);
      if (enc_en_o) begin
        en_cnt++;
        if (first_en < 0) first_en = cyc;
        last_en = cyc;
      end
      if (row_o == 16'd1 && row1_cyc < 0) row1_cyc = cyc;
      if (done_o) begin
        done_cyc = cyc;
        err_done = int'(err_o);
        break;
      end
    end
    tick();
  endtask

  typedef struct {
    int rows;
    bit drop;
    int exp_en;
    int exp_done;
    int exp_err;
  } run_vec_t;

  task automatic check_run(input string tag, input int rows, input bit drop, input int exp_en,
                           input int exp_done, input int exp_err, input int exp_pre);
    int en_cnt, first_en, last_en, done_cyc, err_done, row1_cyc, err_pre, err_c1;
    do_run(rows, drop, en_cnt, first_en, last_en, done_cyc, err_done, row1_cyc, err_pre, err_c1);
    chk({tag, "_err_sticky"}, err_pre, exp_pre);
    chk({tag, "_err_cleared"}, err_c1, 0);
    chk({tag, "_en_cycles"}, en_cnt, exp_en);
    chk({tag, "_en_first"}, first_en, (exp_en > 0) ? 1 : -1);
    chk({tag, "_en_last"}, last_en, (exp_en > 0) ? exp_en : -1);
    chk({tag, "_done_cycle"}, done_cyc, exp_done);
    chk({tag, "_err_at_done"}, err_done, exp_err);
    chk({tag, "_row1_cycle"}, row1_cyc, (rows >= 2) ? 1 + CPE * TD : -1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    run_vec_t vecs[6];
    int prev_err;
    int en_cnt, first_en, last_en, done_cyc, err_done, row1_cyc, err_pre, err_c1;

    vecs[0] = '{rows: 2, drop: 1'b0, exp_en: 64, exp_done: 66, exp_err: 0};
    vecs[1] = '{rows: 2, drop: 1'b1, exp_en: 64, exp_done: 66, exp_err: 1};
    vecs[2] = '{rows: 2, drop: 1'b0, exp_en: 64, exp_done: 66, exp_err: 0};
    vecs[3] = '{rows: 0, drop: 1'b0, exp_en: 0,  exp_done: 1,  exp_err: 0};
    vecs[4] = '{rows: 1, drop: 1'b0, exp_en: 32, exp_done: 34, exp_err: 0};
    vecs[5] = '{rows: 3, drop: 1'b1, exp_en: 96, exp_done: 98, exp_err: 1};

    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_outputs", {thresh_ready_o, enc_we_o, enc_en_o, busy_o, done_o, err_o}, 0);
    chk("rst_row", row_o, 0);
    rst_ni = 1'b1;
    tick();

    // Threshold loads
    do_load(0, 1'b0, "load_full");
    chk("word17_we", q_get(0, 17), 4'b0010);
    chk("word17_addr", q_get(1, 17), 1);
    chk("word80_we", q_get(0, 80), 4'b0010);
    chk("word80_addr", q_get(1, 80), 16);
    chk("word511_we", q_get(0, 511), 4'b1000);
    chk("word511_addr", q_get(1, 511), 127);
    do_load(1, 1'b0, "load_toggle");
    do_load(2, 1'b1, "load_rand_with_start");

    // Table-driven runs
    prev_err = 0;
    for (int v = 0; v < 6; v++) begin
      check_run($sformatf("vec%0d", v), vecs[v].rows, vecs[v].drop, vecs[v].exp_en,
                vecs[v].exp_done, vecs[v].exp_err, prev_err);
      prev_err = vecs[v].exp_err;
    end

    // Randomized runs against the run-length model
    for (int r = 0; r < 6; r++) begin
      int  rows = $urandom_range(0, 3);
      bit  drop = (rows > 0) && ($urandom_range(0, 1) == 1);
      int  n    = rows * CPE * TD;
      check_run($sformatf("rand%0d", r), rows, drop, n, (rows == 0) ? 1 : n + 2,
                drop ? 1 : 0, prev_err);
      prev_err = drop ? 1 : 0;
    end

    // Asynchronous reset in the middle of a run
    drop2      = 1'b0;
    start_i    = 1'b1;
    num_rows_i = 16'd2;
    for (int c = 1; c <= 20; c++) begin
      tick();
      start_i = 1'b0;
    end
    chk("midrun_en_before_rst", enc_en_o, 1);
    rst_ni = 1'b0;
    #1;
    chk("midrun_rst_outputs", {thresh_ready_o, enc_we_o, enc_en_o, busy_o, done_o, err_o}, 0);
    chk("midrun_rst_row", row_o, 0);
    tick();
    rst_ni = 1'b1;
    tick();
    do_run(1, 1'b0, en_cnt, first_en, last_en, done_cyc, err_done, row1_cyc, err_pre, err_c1);
    chk("post_rst_done_cycle", done_cyc, 34);
    chk("post_rst_en_cycles", en_cnt, 32);
    chk("post_rst_err", err_done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
